serial_receiver: RTL
====================

// Module: serial_receiver
// PURPOSE
//  Deserialiser for the Transmitter serial link: idle-low line, one start bit '1',
//  then DATA_W data bits MSB first, one bit per SDClk cycle, no stop bit.
//  Sits at the far end of the link, clocked by the received SDClk.
//  Rebuilds the parallel word and holds it in an output register with a Full/Ack
//  handshake. Reports overrun when a new word completes before the held one is taken.
// PARAMETERS
//  DATA_W     8    data bits per frame; frame length is DATA_W+1 cycles
// PORTS
//  Clk       in   1       link clock (SDClk); all state updates on posedge
//  Reset_n   in   1       asynchronous, active-low reset
//  SDin      in   1       serial data line (SDout of the transmitter)
//  PDout     out  DATA_W  received word, held while Full=1
//  Full      out  1       PDout holds an unconsumed word
//  Ack       in   1       consumer takes PDout; valid only while Full=1
//  Busy      out  1       frame in progress (state SHIFT)
//  Overrun   out  1       sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, bit counter=0, shift reg=0, PDout=0,
//   Full=0, Busy=0, Overrun=0. Reset mid-frame discards the partial word.
//  FSM, 2 states:
//   IDLE : SDin sampled each edge; SDin=1 -> SHIFT, cnt<=0; SDin=0 -> stay.
//   SHIFT: each edge sr<={sr[DATA_W-2:0],SDin}, cnt<=cnt+1.
//          On the edge with cnt==DATA_W-1 the word {sr[DATA_W-2:0],SDin} is
//          complete -> state IDLE, cnt<=0, deliver (below).
//   SDin is ignored for start detection while in SHIFT; a '1' data bit never restarts.
//  Timing: start bit sampled at edge E0; D[DATA_W-1] at E1 ... D0 at E(DATA_W);
//   PDout/Full update at E(DATA_W). Back-to-back frames are supported: a start bit
//   sampled at E(DATA_W+1) is accepted with no gap cycle.
//  Delivery at completion edge:
//   Full=0, or Full=1 with Ack=1 : PDout<=word, Full<=1.
//   Full=1 with Ack=0            : word dropped, PDout unchanged, Overrun<=1.
//  Ack: Ack=1 while Full=1 and no completion -> Full<=0. Ack=1 (any edge) clears
//   Overrun unless the same edge sets it (set wins). Ack while Full=0 ignored.
//  Busy = (state==SHIFT), registered; cnt width = clog2(DATA_W).
//  No metastability sync: SDin is synchronous to Clk by construction of the link.
// STRUCTURE
//  Shared package serial_pkg: DATA_W default, FRAME_LEN=DATA_W+1, state encoding
//   (IDLE, SHIFT), start-bit value constant '1'; the transmitter uses the same.
//  One sub-module: serial_shift_in (DATA_W-bit MSB-first shift-in register with
//   enable and async clear); FSM, counter and output holding logic stay at top.
// TESTING
//  1 SDin = 1,1,0,1,0,0,1,0,1 from IDLE -> PDout=8'hA5, Full=1 at 9th edge, Busy
//    high for 8 cycles, Overrun=0.
//  2 Frames 8'h3C,8'hC3 back-to-back, no gap, Ack pulsed after first -> both
//    received in order, Overrun=0.
//  3 Frames 8'h11 then 8'h22, no Ack -> PDout stays 8'h11, Overrun=1; Ack -> Full=0,
//    Overrun=0.
//  4 Ack asserted on completion edge of 8'h22 while holding 8'h11 -> PDout=8'h22,
//    Full stays 1, Overrun=0.
//  5 Reset_n low after 4 data bits of 8'hFF -> outputs reset immediately; next frame
//    8'h81 received exactly.
//  6 Loopback with Transmitter, PDin=8'h5A, Send rising -> PDout=8'h5A, Full=1, 10
//    edges after the edge that sampled Send high; idle zeros afterwards leave Full unchanged.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver).
// Frame: start bit '1', then DATA_W data bits MSB first, no stop bit.
package serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_LEN  = DATA_W_DEF + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic START_BIT = 1'b1;

  // Bit counter width; never below one bit so narrow frames still elaborate.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Receiver-side link bundle: serial input, parallel output and the Full/Ack handshake.
// Handshake: Full=1 means PDout holds an unconsumed word; Ack=1 takes it (Ack is ignored while Full=0).
interface serial_receiver_if
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              SDin;
  logic [DATA_W-1:0] PDout;
  logic              Full;
  logic              Ack;
  logic              Busy;
  logic              Overrun;
  logic [0:0]        dbg_state;

  modport slave (
    input  SDin, Ack,
    output PDout, Full, Busy, Overrun, dbg_state
  );

  modport master (
    output SDin, Ack,
    input  PDout, Full, Busy, Overrun, dbg_state
  );

endinterface

// File: rtl/serial_shift_in.sv
// MSB-first shift-in register with enable and asynchronous clear.
module serial_shift_in #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {q_q[W-2:0], din_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_receiver.sv
// Serial link deserialiser: detects the start bit, shifts in DATA_W bits and
// holds the finished word behind a Full/Ack handshake with sticky overrun.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  serial_receiver_if.slave bus
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pdout_q, pdout_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] word;
  logic              shifting;
  logic              complete;
  logic              accept;
  logic              sr_unused_msb;

  assign shifting = (state_q == ST_SHIFT);
  assign complete = shifting && (cnt_q == CNT_LAST);
  assign accept   = !full_q || bus.Ack;

  // The last data bit is taken straight from the line, so the register MSB is never needed.
  assign word          = {sr_q[DATA_W-2:0], bus.SDin};
  assign sr_unused_msb = sr_q[DATA_W-1];

  serial_shift_in #(
    .W(DATA_W)
  ) u_shift_in (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .en_i   (shifting),
    .din_i  (bus.SDin),
    .q_o    (sr_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pdout_d = pdout_q;
    full_d  = full_q;
    ovr_d   = ovr_q;

    if (state_q == ST_IDLE) begin
      if (bus.SDin == START_BIT) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (complete) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end

    if (complete && accept) begin
      pdout_d = word;
      full_d  = 1'b1;
    end else if (bus.Ack && full_q) begin
      full_d = 1'b0;
    end

    // A drop on this edge outranks an Ack clearing the flag.
    if (complete && !accept) begin
      ovr_d = 1'b1;
    end else if (bus.Ack) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pdout_q <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pdout_q <= pdout_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.PDout     = pdout_q;
  assign bus.Full      = full_q;
  assign bus.Overrun   = ovr_q;
  assign bus.Busy      = shifting;
  assign bus.dbg_state = state_q;

endmodule
